// File: rtl/tmds_pkg.sv
// Shared TMDS constants: control tokens, clock-lane pattern, colour-bar table and a popcount helper.
package tmds_pkg;

  localparam logic [9:0] CTRL_TOK_00 = 10'h354;
  localparam logic [9:0] CTRL_TOK_01 = 10'h0AB;
  localparam logic [9:0] CTRL_TOK_10 = 10'h154;
  localparam logic [9:0] CTRL_TOK_11 = 10'h2AB;
  localparam logic [9:0] CLK_PATTERN = 10'h01F;

  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    logic [9:0] tok;
    case (c)
      2'b00:   tok = CTRL_TOK_00;
      2'b01:   tok = CTRL_TOK_01;
      2'b10:   tok = CTRL_TOK_10;
      default: tok = CTRL_TOK_11;
    endcase
    return tok;
  endfunction

  // Bar colours as {red, green, blue}, index 0 drawn first.
  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    logic [23:0] rgb;
    case (idx)
      3'd0:    rgb = 24'hFFFFFF;
      3'd1:    rgb = 24'hFFFF00;
      3'd2:    rgb = 24'h00FFFF;
      3'd3:    rgb = 24'h00FF00;
      3'd4:    rgb = 24'hFF00FF;
      3'd5:    rgb = 24'hFF0000;
      3'd6:    rgb = 24'h0000FF;
      default: rgb = 24'h000000;
    endcase
    return rgb;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/tmds_lane_enc.sv
// One TMDS lane: stage 1 transition minimisation, stage 2 DC balance with running disparity.
// Two-clock latency, no flow control.
module tmds_lane_enc
  import tmds_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       de,
  input  logic [1:0] ctrl,
  input  logic [7:0] data,
  output logic [9:0] sym
);

  logic [3:0]        n1_d;
  logic              use_xnor;
  logic [8:0]        qm_d;
  logic [8:0]        qm;
  logic [3:0]        n1;
  logic              de_s1;
  logic [1:0]        ctrl_s1;
  logic signed [4:0] cnt;
  logic signed [4:0] cnt_nx;
  logic signed [4:0] disp;
  logic signed [4:0] qm8_x2;
  logic signed [4:0] inv_x2;
  logic [9:0]        sym_nx;

  always_comb begin
    n1_d     = popcount8(data);
    use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !data[0]);
    qm_d     = '0;
    qm_d[0]  = data[0];
    for (int i = 1; i < 8; i++)
      qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ data[i]) : (qm_d[i-1] ^ data[i]);
    qm_d[8]  = ~use_xnor;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qm      <= '0;
      n1      <= '0;
      de_s1   <= 1'b0;
      ctrl_s1 <= 2'b00;
    end else begin
      qm      <= qm_d;
      n1      <= popcount8(qm_d[7:0]);
      de_s1   <= de;
      ctrl_s1 <= ctrl;
    end
  end

  // disp = n1 - n0 = 2*n1 - 8; 5-bit modular arithmetic keeps the -8..+8 range exact.
  always_comb begin
    disp   = $signed({n1, 1'b0} - 5'd8);
    qm8_x2 = qm[8] ? 5'sd2 : 5'sd0;
    inv_x2 = qm[8] ? 5'sd0 : 5'sd2;
    sym_nx = ctrl_token(ctrl_s1);
    cnt_nx = '0;
    if (de_s1) begin
      if ((cnt == 5'sd0) || (n1 == 4'd4)) begin
        sym_nx = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
        cnt_nx = qm[8] ? (cnt + disp) : (cnt - disp);
      end else if (((cnt > 5'sd0) && (n1 > 4'd4)) || ((cnt < 5'sd0) && (n1 < 4'd4))) begin
        sym_nx = {1'b1, qm[8], ~qm[7:0]};
        cnt_nx = cnt + qm8_x2 - disp;
      end else begin
        sym_nx = {1'b0, qm[8], qm[7:0]};
        cnt_nx = cnt + disp - inv_x2;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym <= CTRL_TOK_00;
      cnt <= '0;
    end else begin
      sym <= sym_nx;
      cnt <= cnt_nx;
    end
  end

endmodule

// File: rtl/tmds_encoder_4lane.sv
// Four-lane TMDS encoder (B/G/R + clock lane), two-clock latency, no flow control.
// Define TMDS_TESTPAT_EN to add test_en and an internal 8-bar colour generator.
module tmds_encoder_4lane
  import tmds_pkg::*;
#(
  parameter int BAR_W = 80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       de,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
`ifdef TMDS_TESTPAT_EN
  input  logic       test_en,
`endif
  output logic [9:0] tmds_0,
  output logic [9:0] tmds_1,
  output logic [9:0] tmds_2,
  output logic [9:0] tmds_3
);

  if (BAR_W < 1) begin : g_bar_w_check
    $error("BAR_W must be at least 1");
  end

  logic [7:0] pix_r;
  logic [7:0] pix_g;
  logic [7:0] pix_b;

`ifdef TMDS_TESTPAT_EN
  localparam int PIX_W = $clog2(BAR_W) + 1;

  logic [PIX_W-1:0] pix_cnt;
  logic [2:0]       bar_idx;

  // Counter restarts on every blanking cycle so each line begins on white.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt <= '0;
      bar_idx <= '0;
    end else if (!de) begin
      pix_cnt <= '0;
      bar_idx <= '0;
    end else if (pix_cnt == PIX_W'(BAR_W - 1)) begin
      pix_cnt <= '0;
      bar_idx <= bar_idx + 3'd1;
    end else begin
      pix_cnt <= pix_cnt + PIX_W'(1);
    end
  end

  assign {pix_r, pix_g, pix_b} = test_en ? bar_rgb(bar_idx) : {red, green, blue};
`else
  assign {pix_r, pix_g, pix_b} = {red, green, blue};
`endif

  tmds_lane_enc u_lane0 (
    .clk  (clk),
    .rst  (rst),
    .de   (de),
    .ctrl ({vsync, hsync}),
    .data (pix_b),
    .sym  (tmds_0)
  );

  tmds_lane_enc u_lane1 (
    .clk  (clk),
    .rst  (rst),
    .de   (de),
    .ctrl (2'b00),
    .data (pix_g),
    .sym  (tmds_1)
  );

  tmds_lane_enc u_lane2 (
    .clk  (clk),
    .rst  (rst),
    .de   (de),
    .ctrl (2'b00),
    .data (pix_r),
    .sym  (tmds_2)
  );

  assign tmds_3 = CLK_PATTERN;

endmodule

// File: tb/tb_tmds_encoder_4lane.sv
// Scoreboard bench for tmds_encoder_4lane: directed corner cases plus randomized video against a reference model.
module tb_tmds_encoder_4lane;

  localparam int BAR_W = 80;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       de = 1'b0;
  logic       hsync = 1'b0;
  logic       vsync = 1'b0;
  logic [7:0] red = '0;
  logic [7:0] green = '0;
  logic [7:0] blue = '0;
`ifdef TMDS_TESTPAT_EN
  logic       test_en = 1'b0;
`endif
  logic [9:0] tmds_0;
  logic [9:0] tmds_1;
  logic [9:0] tmds_2;
  logic [9:0] tmds_3;

  tmds_encoder_4lane #(.BAR_W(BAR_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .de     (de),
    .hsync  (hsync),
    .vsync  (vsync),
    .red    (red),
    .green  (green),
    .blue   (blue),
`ifdef TMDS_TESTPAT_EN
    .test_en(test_en),
`endif
    .tmds_0 (tmds_0),
    .tmds_1 (tmds_1),
    .tmds_2 (tmds_2),
    .tmds_3 (tmds_3)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [9:0] s0;
    logic [9:0] s1;
    logic [9:0] s2;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   mcnt[3];
  int   run_pix = 0;

  // Reference encoder: running disparity kept as a plain integer per lane.
  function automatic logic [9:0] ref_sym(input int lane, input logic den,
                                         input logic [1:0] c, input logic [7:0] d);
    logic [8:0] qm;
    logic [9:0] s;
    int         nd, n1, n0;
    bit         xn;
    if (!den) begin
      mcnt[lane] = 0;
      case (c)
        2'b00:   return 10'h354;
        2'b01:   return 10'h0AB;
        2'b10:   return 10'h154;
        default: return 10'h2AB;
      endcase
    end
    nd = $countones(d);
    xn = (nd > 4) || (nd == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !xn;
    n1 = $countones(qm[7:0]);
    n0 = 8 - n1;
    if (mcnt[lane] == 0 || n1 == n0) begin
      s = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      mcnt[lane] += qm[8] ? (n1 - n0) : (n0 - n1);
    end else if ((mcnt[lane] > 0 && n1 > n0) || (mcnt[lane] < 0 && n0 > n1)) begin
      s = {1'b1, qm[8], ~qm[7:0]};
      mcnt[lane] += 2 * int'(qm[8]) + (n0 - n1);
    end else begin
      s = {1'b0, qm[8], qm[7:0]};
      mcnt[lane] += (n1 - n0) - 2 * int'(!qm[8]);
    end
    return s;
  endfunction

  function automatic logic [23:0] tb_bar(input int idx);
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic issue(input logic den, input logic hs, input logic vs,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input bit fixed, input logic [9:0] f0, input logic [9:0] f1,
                       input logic [9:0] f2);
    exp_t       e;
    logic [7:0] mr, mg, mb;
    int         pix;
    @(posedge clk);
    #1;
    de = den; hsync = hs; vsync = vs; red = r; green = g; blue = b;
    mr = r; mg = g; mb = b;
    pix = run_pix;
    if (den) run_pix++;
    else run_pix = 0;
`ifdef TMDS_TESTPAT_EN
    if (test_en && den) {mr, mg, mb} = tb_bar((pix / BAR_W) % 8);
`endif
    if (pix < 0) pix = 0;
    e.due = cyc + 2;
    e.s0  = ref_sym(0, den, {vs, hs}, mb);
    e.s1  = ref_sym(1, den, 2'b00, mg);
    e.s2  = ref_sym(2, den, 2'b00, mr);
    if (fixed) begin
      e.s0 = f0; e.s1 = f1; e.s2 = f2;
    end
    sbq.push_back(e);
  endtask

  task automatic check_now(input string name, input logic [9:0] got, input logic [9:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, req);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_now("rst_tmds_0", tmds_0, 10'h354);
    check_now("rst_tmds_1", tmds_1, 10'h354);
    check_now("rst_tmds_2", tmds_2, 10'h354);
    check_now("rst_tmds_3", tmds_3, 10'h01F);
    sbq.delete();
    for (int l = 0; l < 3; l++) mcnt[l] = 0;
    run_pix = 0;
    de = 1'b0; hsync = 1'b0; vsync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: every cycle out of reset, pop the entry due now and compare all lanes.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (tmds_3 !== 10'h01F) begin
        errors++;
        $display("FAIL tmds_3 cyc %0d got %h required 01f", cyc, tmds_3);
      end
      while (sbq.size() > 0 && sbq[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_symbol due %0d at cyc %0d", sbq[0].due, cyc);
        void'(sbq.pop_front());
      end
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        exp_t e;
        e = sbq.pop_front();
        checks += 3;
        if (tmds_0 !== e.s0) begin
          errors++;
          $display("FAIL tmds_0 cyc %0d got %h required %h", cyc, tmds_0, e.s0);
        end
        if (tmds_1 !== e.s1) begin
          errors++;
          $display("FAIL tmds_1 cyc %0d got %h required %h", cyc, tmds_1, e.s1);
        end
        if (tmds_2 !== e.s2) begin
          errors++;
          $display("FAIL tmds_2 cyc %0d got %h required %h", cyc, tmds_2, e.s2);
        end
      end
    end
  end

  initial begin
    logic       cur_de;
    logic [7:0] rr, gg, bb;
    logic       hs, vs;
    for (int l = 0; l < 3; l++) mcnt[l] = 0;
    #1;
    do_reset();

    // Control tokens on lane 0.
    issue(1'b0, 1'b1, 1'b0, 8'h12, 8'h34, 8'h56, 1, 10'h0AB, 10'h354, 10'h354);
    issue(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1, 10'h154, 10'h354, 10'h354);
    issue(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1, 10'h2AB, 10'h354, 10'h354);
    issue(1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF, 1, 10'h354, 10'h354, 10'h354);

    // Disparity walk from zero, then re-entry after a one-cycle gap.
    issue(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1, 10'h100, 10'h100, 10'h100);
    issue(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1, 10'h3FF, 10'h3FF, 10'h3FF);
    issue(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1, 10'h100, 10'h100, 10'h100);
    issue(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1, 10'h354, 10'h354, 10'h354);
    issue(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1, 10'h100, 10'h100, 10'h100);

    // Single-cycle de pulse: white encodes to 10'h200 from cnt=0.
    issue(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 0, '0, '0, '0);
    issue(1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF, 1, 10'h200, 10'h200, 10'h200);
    issue(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1, 10'h354, 10'h354, 10'h354);

    // Reset during active video: pipeline contents are dropped.
    repeat (4) issue(1'b1, 1'b0, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 0, '0, '0, '0);
    do_reset();
    issue(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1, 10'h100, 10'h100, 10'h100);

`ifdef TMDS_TESTPAT_EN
    issue(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 0, '0, '0, '0);
    test_en = 1'b1;
    issue(1'b1, 1'b0, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 1, 10'h200, 10'h200, 10'h200);
    for (int p = 1; p < 9 * BAR_W + 5; p++)
      issue(1'b1, 1'b0, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 0, '0, '0, '0);
    issue(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 0, '0, '0, '0);
    test_en = 1'b0;
`endif

    // Randomized video with runs of active and blanking.
    cur_de = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 9) == 0) cur_de = ~cur_de;
      case ($urandom_range(0, 3))
        0:       begin rr = 8'h00; gg = 8'hFF; bb = 8'h00; end
        1:       begin rr = 8'hFF; gg = 8'h0F; bb = 8'hF0; end
        default: begin rr = 8'($urandom); gg = 8'($urandom); bb = 8'($urandom); end
      endcase
      hs = 1'($urandom_range(0, 1));
      vs = 1'($urandom_range(0, 1));
      issue(cur_de, hs, vs, rr, gg, bb, 0, '0, '0, '0);
      if (n == 700) do_reset();
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain leftover %0d required 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
